pll_clken_manager: RTL and testbench



---
 rtl/pll_clk_pkg.sv | 15 +
 rtl/clken_divider.sv | 67 ++++++
 rtl/pll_clken_manager.sv | 178 +++++++++++++++++
 tb/tb_pll_clken_manager.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_clk_pkg.sv
// Shared types and helpers for the PLL clock-enable manager.
package pll_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Width of the channel index; kept at least 1 so a single-channel build still has a register.
    function automatic int idx_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clken_divider.sv
// One channel of programmable clock-enable generation with glitch-free divisor adoption.
module clken_divider #(
    parameter int               DIV_W       = 8,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chan_rst,
    input  logic [DIV_W-1:0] shadow_div,
    input  logic             pending,
    output logic             clk_en,
    output logic             taken
);

    localparam logic [DIV_W-1:0] ONE = 1;

    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [DIV_W-1:0] d_eff;
    logic             last;

    assign d_eff = (active_q == '0) ? ONE : active_q;
    assign last  = (cnt_q == (d_eff - ONE));

    // The divisor only changes at a wrap (or while held in reset), so every period is whole.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        en_d     = 1'b0;
        taken    = 1'b0;
        if (chan_rst) begin
            cnt_d = '0;
            if (pending) begin
                active_d = shadow_div;
                taken    = 1'b1;
            end
        end else begin
            en_d = last;
            if (last) begin
                cnt_d = '0;
                if (pending) begin
                    active_d = shadow_div;
                    taken    = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= DEFAULT_DIV;
            cnt_q    <= '0;
            en_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
        end
    end

    // Masking keeps a pulse computed just before a lock-loss reset from leaking out.
    assign clk_en = en_q & ~chan_rst;

endmodule

// File: rtl/pll_clken_manager.sv
// Qualifies PLL lock, sequences per-channel reset release and drives per-channel clock enables.
module pll_clken_manager
    import pll_clk_pkg::*;
#(
    parameter int N_CH               = 4,
    parameter int DIV_W              = 8,
    parameter int DEFAULT_DIV        = 1,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RST_GAP            = 8,
    parameter int CNT_W              = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  locked,
    input  logic [N_CH*DIV_W-1:0] div_in,
    input  logic                  div_load,
    input  logic                  clr_status,
    output logic [N_CH-1:0]       rst_out,
    output logic [N_CH-1:0]       clk_en,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [CNT_W-1:0]      lock_loss_cnt
);

    localparam int IDX_W = idx_width(N_CH);
    localparam int ST_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GAP_W = $clog2(RST_GAP + 1);

    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RST_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);
    localparam logic [ST_W-1:0]  ST_ONE   = 1;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

    logic                sync1_q, sync2_q;
    logic                locked_s;
    state_e              state_q, state_d;
    logic [ST_W-1:0]     stable_q, stable_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_CH-1:0]     rst_q, rst_d;
    logic                ready_q, ready_d;
    logic                lost_q, lost_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    assign locked_s = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        ready_d  = ready_q;
        lost_d   = lost_q & ~clr_status;
        cnt_d    = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!locked_s) begin
                    stable_d = '0;
                end else if (stable_q == ST_LAST) begin
                    state_d  = RELEASE;
                    stable_d = '0;
                    gap_d    = '0;
                    idx_d    = '0;
                end else begin
                    stable_d = stable_q + ST_ONE;
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    // Lock lost after qualification: everything back into reset, event recorded.
                    state_d  = WAIT_LOCK;
                    stable_d = '0;
                    gap_d    = '0;
                    idx_d    = '0;
                    rst_d    = '1;
                    ready_d  = 1'b0;
                    lost_d   = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (state_q == RELEASE) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d        = '0;
                        rst_d[idx_q] = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            stable_q <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] shadow_q;
            logic             pending_q;
            logic             taken;

            // A fresh load wins over a same-cycle adoption so the newer value is never lost.
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_q  <= DIV_RST;
                    pending_q <= 1'b0;
                end else if (div_load) begin
                    shadow_q  <= div_in[gi*DIV_W +: DIV_W];
                    pending_q <= 1'b1;
                end else if (taken) begin
                    pending_q <= 1'b0;
                end
            end

            clken_divider #(
                .DIV_W      (DIV_W),
                .DEFAULT_DIV(DIV_RST)
            ) u_div (
                .clk       (clk),
                .reset     (reset),
                .chan_rst  (rst_q[gi]),
                .shadow_div(shadow_q),
                .pending   (pending_q),
                .clk_en    (clk_en[gi]),
                .taken     (taken)
            );
        end
    endgenerate

    assign rst_out       = rst_q;
    assign ready         = ready_q;
    assign lock_lost     = lost_q;
    assign lock_loss_cnt = cnt_q;

endmodule

// File: tb/tb_pll_clken_manager.sv
// Directed self-checking bench for pll_clken_manager (4 channels, 3-bit lock-loss counter).
module tb_pll_clken_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic        locked;
    logic [31:0] div_in;
    logic        div_load;
    logic        clr_status;
    logic [3:0]  rst_out;
    logic [3:0]  clk_en;
    logic        ready;
    logic        lock_lost;
    logic [2:0]  lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    pll_clken_manager #(
        .N_CH              (4),
        .DIV_W             (8),
        .DEFAULT_DIV       (1),
        .LOCK_STABLE_CYCLES(16),
        .RST_GAP           (8),
        .CNT_W             (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .locked       (locked),
        .div_in       (div_in),
        .div_load     (div_load),
        .clr_status   (clr_status),
        .rst_out      (rst_out),
        .clk_en       (clk_en),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; locked = 1'b0; div_in = '0; div_load = 1'b0; clr_status = 1'b0;
        repeat (3) tick();
        total++;
        if ({rst_out, clk_en, ready, lock_lost, lock_loss_cnt} !== {4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_values got rst=%b en=%b rdy=%b lost=%b cnt=%0d exp rst=1111 en=0000 rdy=0 lost=0 cnt=0",
                     rst_out, clk_en, ready, lock_lost, lock_loss_cnt);
        end
        reset = 1'b0;
        repeat (5) tick();
        total++;
        if ({rst_out, ready} !== {4'b1111, 1'b0}) begin
            bad++;
            $display("FAIL idle_unlocked got rst=%b rdy=%b exp rst=1111 rdy=0", rst_out, ready);
        end
    endtask

    // locked rises at k=0; locked_s=1 from k=2; channel i released at k=26+8i.
    task automatic test_release;
        logic [3:0] exp_rst, exp_en;
        locked = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                exp_rst[i] = (k < 26 + 8*i);
                exp_en[i]  = (k >= 27 + 8*i);
            end
            total++;
            if (rst_out !== exp_rst || ready !== (k >= 50) || clk_en !== exp_en) begin
                bad++;
                $display("FAIL release_seq k=%0d got rst=%b rdy=%b en=%b exp rst=%b rdy=%b en=%b",
                         k, rst_out, ready, clk_en, exp_rst, (k >= 50), exp_en);
            end
        end
    endtask

    task automatic test_divide;
        logic [3:0] hist [100];
        int dv [4] = '{1, 1, 3, 5};
        int f;
        logic exp_bit;
        div_in = {8'd5, 8'd3, 8'd1, 8'd0};
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        repeat (20) tick();
        for (int k = 0; k < 100; k++) begin
            tick();
            hist[k] = clk_en;
        end
        for (int c = 0; c < 4; c++) begin
            f = -1;
            for (int k = 0; k < dv[c]; k++) if (f < 0 && hist[k][c]) f = k;
            if (f < 0) f = 0;
            for (int k = 0; k < 100; k++) begin
                exp_bit = (k >= f) && (((k - f) % dv[c]) == 0);
                total++;
                if (hist[k][c] !== exp_bit) begin
                    bad++;
                    $display("FAIL divide ch=%0d k=%0d got=%b exp=%b", c, k, hist[k][c], exp_bit);
                end
            end
        end
    endtask

    task automatic wait_pulse3(input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (clk_en[3]) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s got no ch3 pulse exp pulse within 40 cycles", name);
        end
    endtask

    task automatic test_update;
        logic exp_bit;
        // ch3 at 5: load 2 one cycle after a pulse; old period completes first.
        wait_pulse3("upd_sync_a");
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_bit = (k == 5 || k == 7 || k == 9 || k == 11);
            total++;
            if (clk_en[3] !== exp_bit) begin
                bad++;
                $display("FAIL upd_5to2 k=%0d got=%b exp=%b", k, clk_en[3], exp_bit);
            end
            if (k == 1) begin div_in[31:24] = 8'd2; div_load = 1'b1; end
            if (k == 2) div_load = 1'b0;
        end
        div_in[31:24] = 8'd5; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        repeat (15) tick();
        // Two loads (7 then 4) inside one period: only 4 is applied at the wrap.
        wait_pulse3("upd_sync_b");
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_bit = (k == 5 || k == 9 || k == 13);
            total++;
            if (clk_en[3] !== exp_bit) begin
                bad++;
                $display("FAIL upd_last_wins k=%0d got=%b exp=%b", k, clk_en[3], exp_bit);
            end
            if (k == 1) begin div_in[31:24] = 8'd7; div_load = 1'b1; end
            if (k == 2) div_load = 1'b0;
            if (k == 3) begin div_in[31:24] = 8'd4; div_load = 1'b1; end
            if (k == 4) div_load = 1'b0;
        end
    endtask

    // One-cycle locked drop at k=0; loss visible at k=3; relock with locked_s=1 from k=3.
    task automatic test_lock_loss;
        logic [3:0] exp_rst;
        locked = 1'b0;
        tick();
        total++;
        if (rst_out !== 4'b0000 || ready !== 1'b1) begin
            bad++;
            $display("FAIL loss_k1 got rst=%b rdy=%b exp rst=0000 rdy=1", rst_out, ready);
        end
        locked = 1'b1;
        tick();
        total++;
        if (rst_out !== 4'b0000 || ready !== 1'b1) begin
            bad++;
            $display("FAIL loss_k2 got rst=%b rdy=%b exp rst=0000 rdy=1", rst_out, ready);
        end
        tick();
        total++;
        if ({rst_out, ready, clk_en, lock_lost, lock_loss_cnt} !== {4'b1111, 1'b0, 4'b0000, 1'b1, 3'd1}) begin
            bad++;
            $display("FAIL loss_k3 got rst=%b rdy=%b en=%b lost=%b cnt=%0d exp rst=1111 rdy=0 en=0000 lost=1 cnt=1",
                     rst_out, ready, clk_en, lock_lost, lock_loss_cnt);
        end
        for (int k = 4; k <= 56; k++) begin
            tick();
            for (int i = 0; i < 4; i++) exp_rst[i] = (k < 27 + 8*i);
            total++;
            if (rst_out !== exp_rst || ready !== (k >= 51)) begin
                bad++;
                $display("FAIL relock_seq k=%0d got rst=%b rdy=%b exp rst=%b rdy=%b",
                         k, rst_out, ready, exp_rst, (k >= 51));
            end
            for (int i = 0; i < 4; i++) begin
                if (k <= 27 + 8*i) begin
                    total++;
                    if (clk_en[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL relock_en_early ch=%0d k=%0d got=%b exp=0", i, k, clk_en[i]);
                    end
                end
            end
        end
    endtask

    task automatic wait_ready(input string name);
        bit ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            tick();
            if (ready) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got ready=0 exp ready=1 within 80 cycles", name);
        end
    endtask

    task automatic test_saturation;
        logic [2:0] exp_cnt;
        for (int it = 0; it < 10; it++) begin
            locked = 1'b0;
            tick();
            locked = 1'b1;
            repeat (2) tick();
            exp_cnt = (it + 2 >= 7) ? 3'd7 : 3'(it + 2);
            total++;
            if (lock_loss_cnt !== exp_cnt || lock_lost !== 1'b1) begin
                bad++;
                $display("FAIL sat_cnt it=%0d got cnt=%0d lost=%b exp cnt=%0d lost=1", it, lock_loss_cnt, lock_lost, exp_cnt);
            end
            wait_ready("sat_relock");
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++;
        if (lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL clr_alone got lost=%b exp lost=0", lock_lost);
        end
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++;
        if (lock_lost !== 1'b1 || lock_loss_cnt !== 3'd7) begin
            bad++;
            $display("FAIL clr_vs_set got lost=%b cnt=%0d exp lost=1 cnt=7", lock_lost, lock_loss_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick();
            if (rst_out == 4'b1100) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_sync got rst=%b exp rst=1100 within 80 cycles", rst_out);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({rst_out, clk_en, ready, lock_lost, lock_loss_cnt} !== {4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL mid_reset got rst=%b en=%b rdy=%b lost=%b cnt=%0d exp rst=1111 en=0000 rdy=0 lost=0 cnt=0",
                     rst_out, clk_en, ready, lock_lost, lock_loss_cnt);
        end
        reset = 1'b0;
        // locked_s=1 from k=2, glitch drops it at k=12, stable again from k=13 -> ch0 released at k=37.
        for (int k = 1; k <= 38; k++) begin
            tick();
            total++;
            if (rst_out[0] !== (k < 37) || ready !== 1'b0) begin
                bad++;
                $display("FAIL glitch_restart k=%0d got rst0=%b rdy=%b exp rst0=%b rdy=0", k, rst_out[0], ready, (k < 37));
            end
            if (k == 10) locked = 1'b0;
            if (k == 11) locked = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_divide();
        test_update();
        test_lock_loss();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
